// File: rtl/vending_machine_param.sv
// vending_machine_param
// Parametrised vending controller with per-item prices, a credit ceiling, an
// inactivity timeout and a counter-driven change dispenser. It returns one
// coin per cycle. All outputs are registered (Moore style).
//
// Optional feature macro: VM_QUARTER_EN
//   defined   -> the quarter input is credited as 25 cents
//   undefined -> every quarter pulse is rejected and it is ignored by the
//                simultaneous-coin rule
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   item_valid/item_sel item selection strobe and index
//   nickel/dime/quarter one-cycle coin pulses
//   cancel              abort the current transaction
//   vend, vend_item     one-cycle dispense pulse and the dispensed index
//   change_5C/10C       one change coin per asserted cycle
//   coin_reject         a coin was returned with no credit (the cycle after it)
//   busy                high in every state except IDLE
//   credit              current credit in cents
module vending_machine_param #(
  parameter int NUM_ITEMS      = 4,
  parameter int CREDIT_W       = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd35, 8'd25, 8'd20, 8'd15},
  parameter int MAX_CREDIT     = 100,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                item_valid,
  input  logic [IDX_W-1:0]    item_sel,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                vend,
  output logic [IDX_W-1:0]    vend_item,
  output logic                change_5C,
  output logic                change_10C,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMR_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0] C5    = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0] C10   = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0] C25   = (CREDIT_W+1)'(25);
  localparam logic [IDX_W:0]    N_ITEMS = (IDX_W+1)'(NUM_ITEMS);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   change;
  logic [TMR_W-1:0]    timer;

  logic [CREDIT_W-1:0] price_sel;
  logic                q_ok, q_bad;
  logic [1:0]          n_coins;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic                in_range, accept, reject, timeout;

`ifdef VM_QUARTER_EN
  assign q_ok  = quarter;
  assign q_bad = 1'b0;
`else
  assign q_ok  = 1'b0;
  assign q_bad = quarter;
`endif

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (item_sel == IDX_W'(i)) price_sel = PRICES[i*CREDIT_W +: CREDIT_W];

    in_range = {1'b0, item_sel} < N_ITEMS;
    n_coins  = {1'b0, nickel} + {1'b0, dime} + {1'b0, q_ok};

    coin_val = '0;
    if (nickel)    coin_val = C5;
    else if (dime) coin_val = C10;
    else if (q_ok) coin_val = C25;

    sum = {1'b0, credit} + coin_val;

    // Only a lone coin that keeps credit within the ceiling is taken, and
    // cancel always wins over a coin arriving on the same edge.
    accept  = (state == COLLECT) && !cancel && (n_coins == 2'd1) && (sum <= MAX_C);
    reject  = q_bad | ((n_coins != 2'd0) && !accept);
    timeout = TMR_EN && (state == COLLECT) && (timer == TMR_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      price       <= '0;
      change      <= '0;
      timer       <= '0;
      credit      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      change_5C   <= 1'b0;
      change_10C  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vend        <= 1'b0;
      change_5C   <= 1'b0;
      change_10C  <= 1'b0;
      coin_reject <= reject;

      case (state)
        IDLE: begin
          if (item_valid && in_range) begin
            idx    <= item_sel;
            price  <= price_sel;
            credit <= '0;
            timer  <= '0;
            busy   <= 1'b1;
            state  <= COLLECT;
          end
        end

        COLLECT: begin
          if (cancel || (timeout && !accept)) begin
            change <= {1'b0, credit};
            credit <= '0;
            if (credit == '0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= CHANGE;
            end
          end else if (accept) begin
            timer <= '0;
            if (sum >= {1'b0, price}) begin
              // Settle the change amount on the way into VEND so the
              // dispenser can start on the very next edge.
              change    <= sum - {1'b0, price};
              credit    <= '0;
              vend      <= 1'b1;
              vend_item <= idx;
              state     <= VEND;
            end else begin
              credit <= sum[CREDIT_W-1:0];
            end
          end else if (TMR_EN) begin
            timer <= timer + 1'b1;
          end
        end

        // VEND and CHANGE share the dispenser: each edge pays out one coin,
        // and the state lingers for the cycle that coin is visible so busy
        // only drops after the last one.
        VEND, CHANGE: begin
          if (change >= C10) begin
            change_10C <= 1'b1;
            change     <= change - C10;
            state      <= CHANGE;
          end else if (change >= C5) begin
            change_5C <= 1'b1;
            change    <= change - C5;
            state     <= CHANGE;
          end else begin
            change <= '0;   // sub-nickel remainder is discarded
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param. Item 3 is priced above the credit
// ceiling so credit saturation can be exercised, and the timeout is short.
module tb_vending_machine_param;

  logic       clk, rst;
  logic       item_valid;
  logic [1:0] item_sel;
  logic       nickel, dime, quarter, cancel;
  logic       vend;
  logic [1:0] vend_item;
  logic       change_5C, change_10C, coin_reject, busy;
  logic [7:0] credit;

  int tests_run    = 0;
  int tests_failed = 0;

  vending_machine_param #(
    .NUM_ITEMS      (4),
    .CREDIT_W       (8),
    .PRICES         ({8'd120, 8'd25, 8'd20, 8'd15}),
    .MAX_CREDIT     (100),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .item_valid  (item_valid),
    .item_sel    (item_sel),
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
    .cancel      (cancel),
    .vend        (vend),
    .vend_item   (vend_item),
    .change_5C   (change_5C),
    .change_10C  (change_10C),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled 1 time unit after the edge they reflect.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [1:0] i);
    item_valid = 1'b1; item_sel = i;
    tick();
    item_valid = 1'b0;
  endtask

  task automatic put(input logic n, input logic d, input logic q);
    nickel = n; dime = d; quarter = q;
    tick();
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
  endtask

  task automatic do_cancel(input logic with_dime);
    cancel = 1'b1; dime = with_dime;
    tick();
    cancel = 1'b0; dime = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    item_valid = 1'b0; item_sel = '0;
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    tick(); tick();
    tests_run++;
    if ({vend, vend_item, change_5C, change_10C, coin_reject, busy} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {vend, vend_item, change_5C, change_10C, coin_reject, busy});
    end
    tests_run++;
    if (credit !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_credit: got %0d expected 0", credit);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_coin();
    put(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (coin_reject !== 1'b1 || busy !== 1'b0 || credit !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_coin: reject=%b busy=%b credit=%0d expected 1 0 0",
               coin_reject, busy, credit);
    end
    tick();
    tests_run++;
    if (coin_reject !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_coin_clear: reject=%b expected 0", coin_reject);
    end
  endtask

  task automatic test_exact_price();
    select(2'd0);
    tests_run++;
    if (busy !== 1'b1 || credit !== 8'd0) begin
      tests_failed++;
      $display("FAIL select_item0: busy=%b credit=%0d expected 1 0", busy, credit);
    end
    put(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (credit !== 8'd10 || vend !== 1'b0) begin
      tests_failed++;
      $display("FAIL item0_dime: credit=%0d vend=%b expected 10 0", credit, vend);
    end
    put(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (vend !== 1'b1 || vend_item !== 2'd0 || credit !== 8'd0) begin
      tests_failed++;
      $display("FAIL item0_vend: vend=%b item=%0d credit=%0d expected 1 0 0",
               vend, vend_item, credit);
    end
    tick();
    tests_run++;
    if (vend !== 1'b0 || change_5C !== 1'b0 || change_10C !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL item0_done: vend=%b c5=%b c10=%b busy=%b expected 0 0 0 0",
               vend, change_5C, change_10C, busy);
    end
  endtask

  task automatic test_quarter();
    select(2'd1);
`ifdef VM_QUARTER_EN
    put(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (vend !== 1'b1 || vend_item !== 2'd1) begin
      tests_failed++;
      $display("FAIL quarter_vend: vend=%b item=%0d expected 1 1", vend, vend_item);
    end
    tick();
    tests_run++;
    if (change_5C !== 1'b1 || change_10C !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL quarter_change: c5=%b c10=%b busy=%b expected 1 0 1",
               change_5C, change_10C, busy);
    end
`else
    put(1'b1, 1'b0, 1'b1);
    tests_run++;
    if (credit !== 8'd5 || coin_reject !== 1'b1) begin
      tests_failed++;
      $display("FAIL quarter_with_nickel: credit=%0d reject=%b expected 5 1",
               credit, coin_reject);
    end
    put(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (credit !== 8'd5 || coin_reject !== 1'b1 || vend !== 1'b0) begin
      tests_failed++;
      $display("FAIL quarter_alone: credit=%0d reject=%b vend=%b expected 5 1 0",
               credit, coin_reject, vend);
    end
    do_cancel(1'b0);
    tick();
    tests_run++;
    if (change_5C !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL quarter_refund: c5=%b busy=%b expected 1 1", change_5C, busy);
    end
`endif
    tick();
    tests_run++;
    if (change_5C !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL quarter_idle: c5=%b busy=%b expected 0 0", change_5C, busy);
    end
  endtask

  task automatic test_overpay();
    select(2'd2);
    put(1'b0, 1'b1, 1'b0);
    put(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (credit !== 8'd20 || vend !== 1'b0) begin
      tests_failed++;
      $display("FAIL overpay_credit: credit=%0d vend=%b expected 20 0", credit, vend);
    end
    put(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (vend !== 1'b1 || vend_item !== 2'd2) begin
      tests_failed++;
      $display("FAIL overpay_vend: vend=%b item=%0d expected 1 2", vend, vend_item);
    end
    tick();
    tests_run++;
    if (change_5C !== 1'b1 || change_10C !== 1'b0 || vend !== 1'b0) begin
      tests_failed++;
      $display("FAIL overpay_change: c5=%b c10=%b vend=%b expected 1 0 0",
               change_5C, change_10C, vend);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || change_5C !== 1'b0) begin
      tests_failed++;
      $display("FAIL overpay_idle: busy=%b c5=%b expected 0 0", busy, change_5C);
    end
  endtask

  task automatic test_cancel();
    select(2'd3);
    for (int i = 0; i < 3; i++) put(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (credit !== 8'd30) begin
      tests_failed++;
      $display("FAIL cancel_credit: got %0d expected 30", credit);
    end
    do_cancel(1'b1);  // same-edge dime must bounce
    tests_run++;
    if (credit !== 8'd0 || coin_reject !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL cancel_edge: credit=%0d reject=%b busy=%b expected 0 1 1",
               credit, coin_reject, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (change_10C !== 1'b1 || change_5C !== 1'b0) begin
        tests_failed++;
        $display("FAIL cancel_dime_%0d: c10=%b c5=%b expected 1 0", i, change_10C, change_5C);
      end
    end
    tick();
    tests_run++;
    if (change_10C !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL cancel_idle: c10=%b busy=%b expected 0 0", change_10C, busy);
    end
  endtask

  task automatic test_saturate();
    int n10, n5;
    bit done;
    n10 = 0; n5 = 0; done = 1'b0;
    select(2'd3);
    for (int i = 0; i < 10; i++) put(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (credit !== 8'd100 || coin_reject !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_fill: credit=%0d reject=%b expected 100 0", credit, coin_reject);
    end
    put(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (credit !== 8'd100 || coin_reject !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_dime11: credit=%0d reject=%b expected 100 1", credit, coin_reject);
    end
    put(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (credit !== 8'd100 || coin_reject !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_nickel: credit=%0d reject=%b expected 100 1", credit, coin_reject);
    end
    do_cancel(1'b0);
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (change_10C) n10++;
      if (change_5C) n5++;
      if (!busy) done = 1'b1;
    end
    tests_run++;
    if (!done || n10 != 10 || n5 != 0) begin
      tests_failed++;
      $display("FAIL sat_refund: done=%b dimes=%0d nickels=%0d expected 1 10 0",
               done, n10, n5);
    end
  endtask

  task automatic test_timeout();
    select(2'd1);
    put(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    tests_run++;
    if (credit !== 8'd5 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_early: credit=%0d busy=%b expected 5 1", credit, busy);
    end
    tick();
    tests_run++;
    if (credit !== 8'd0 || change_5C !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_fire: credit=%0d c5=%b expected 0 0", credit, change_5C);
    end
    tick();
    tests_run++;
    if (change_5C !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_refund: c5=%b expected 1", change_5C);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    select(2'd1);
    put(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (coin_reject !== 1'b1 || credit !== 8'd0) begin
      tests_failed++;
      $display("FAIL simul_reject: reject=%b credit=%0d expected 1 0", coin_reject, credit);
    end
    put(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (coin_reject !== 1'b0 || credit !== 8'd5) begin
      tests_failed++;
      $display("FAIL simul_after: reject=%b credit=%0d expected 0 5", coin_reject, credit);
    end
    do_cancel(1'b0);
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_change();
    int pulses;
    pulses = 0;
    select(2'd3);
    put(1'b0, 1'b1, 1'b0);
    put(1'b0, 1'b1, 1'b0);
    do_cancel(1'b0);
    tick();
    tests_run++;
    if (change_10C !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstchg_first: c10=%b expected 1", change_10C);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({vend, vend_item, change_5C, change_10C, coin_reject, busy} !== 7'b0 || credit !== 8'd0) begin
      tests_failed++;
      $display("FAIL rstchg_async: outs=%b credit=%0d expected 0000000 0",
               {vend, vend_item, change_5C, change_10C, coin_reject, busy}, credit);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (change_10C || change_5C || busy) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL rstchg_after: active cycles=%0d expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_idle_coin();
    test_exact_price();
    test_quarter();
    test_overpay();
    test_cancel();
    test_saturate();
    test_timeout();
    test_simultaneous();
    test_reset_mid_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
